stream_mux_rr: RTL and testbench
================================

Name: stream_mux_rr

Overview:
- Parametrised successor to the 16-bit 4:1 datapath mux.
- Selects one of NCH WIDTH-bit input channels onto a single registered output stream, using valid/ready handshakes on every port.
- Two modes: fixed select, where the channel is chosen by `sel`, and round-robin arbitration.
- Sits between multiple producers (e.g. ALU, memory, immediate paths) and a single consumer stage, where back-pressure is needed.

Parameters:
- WIDTH, 16, data width per channel.
- NCH, 4, number of input channels (2..16, power of two not required).
- SELW, 2, width of `sel`/`out_ch`; must equal ceil(log2(NCH)).
- RR_MODE, 1, 1 = round-robin arbitration; 0 = fixed select via `sel`.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous, active-high.
- in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NCH  per-channel valid.
- in_ready  output  NCH  per-channel ready; at most one bit set.
- sel  input  SELW  channel select; used only when RR_MODE=0.
- out_data  output  WIDTH  registered output data.
- out_ch  output  SELW  index of the channel that supplied out_data.
- out_valid  output  1  out_data/out_ch valid.
- out_ready  input  1  consumer ready.
- sel_err  output  1  one-cycle registered pulse: select out of range.

Behaviour:
- Reset (rst=1 at clk edge):
  - out_valid=0, out_data=0, out_ch=0, sel_err=0, round-robin pointer ptr=0.
  - Any captured beat is discarded.
  - rst has priority over all other activity.
- Clock and reset: one clock; reset is synchronous and active-high.
- accept = !out_valid || out_ready. This means the output register is empty or is being drained this cycle.
- Grant, combinational:
  - RR_MODE=0: grant = sel if sel < NCH and in_valid[sel]; otherwise no grant.
  - RR_MODE=1: grant = the first i with in_valid[i] set, scanning ptr, ptr+1, …, NCH-1, 0, …, ptr-1. No grant if in_valid is all zero.
- in_ready[i] = accept && grant valid && grant==i. in_ready is combinational from in_valid, sel, out_valid, out_ready and ptr. Producers must not make in_valid depend on in_ready.
- Transfer: in_valid[i] && in_ready[i] at a clk edge. On the next cycle: out_data = channel i data, out_ch = i, out_valid = 1.
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 beat per cycle when out_ready stays high. Drain and capture in the same cycle are allowed.
- Hold: when out_valid=1 and out_ready=0, out_data and out_ch stay stable and no in_ready is asserted.
- Empty: if accept=1 and there is no grant, out_valid falls to 0 on the next edge (when draining), or stays 0.
- Pointer (RR_MODE=1 only):
  - On a transfer from channel g, ptr <= (g+1) mod NCH. Wrap from NCH-1 goes to 0.
  - ptr does not change when there is no transfer.
- sel_err (RR_MODE=0 only):
  - Set to 1 for exactly one cycle after any edge where accept=1 and sel >= NCH. This is possible only when NCH is not a power of two.
  - No transfer occurs in that cycle.
  - In RR_MODE=1, sel_err is held at 0.
- Input data on non-granted channels is ignored. Producers must hold data and valid until their own handshake completes.

Test Plan:
- Reset: drive rst=1 for 2 cycles with all in_valid=1 → out_valid=0, out_data=0, out_ch=0, in_ready=0 during reset. The first grant after release goes to channel 0 (RR_MODE=1).
- Fixed select: RR_MODE=0, sel=2, in_data ch2=16'hBEEF, all valid, out_ready=1 → in_ready=4'b0100. One cycle later out_data=16'hBEEF, out_ch=2, out_valid=1. Change sel to 3 (ch3=16'h1234) → next beat is 16'h1234, out_ch=3.
- Round-robin fairness: RR_MODE=1, in_valid=4'b1111 held, out_ready=1 for 8 cycles → out_ch sequence is 0,1,2,3,0,1,2,3. With in_valid=4'b1010, the sequence is 1,3,1,3.
- Back-pressure: out_valid=1 with out_data=16'h00AA, then out_ready=0 for 3 cycles → out_data/out_ch are unchanged and in_ready=0. Raise out_ready → drain and capture of the next beat happen in the same cycle, with no bubble.
- Range error: NCH=3, SELW=2, RR_MODE=0, sel=3, in_valid=3'b111, output empty → in_ready=0, sel_err=1 for one cycle, out_valid stays 0.
- Reset mid-stream: out_valid=1 holding 16'h5555 and ptr=2, assert rst for 1 cycle → out_valid=0 and ptr=0. The next grant with all valid goes to ch0.

Source files
------------

// File: rtl/stream_mux_rr_if.sv
// Handshake bundle between the producers/consumer and the stream_mux_rr block.
// The mux itself connects through the slave modport.
interface stream_mux_rr_if #(
    parameter int WIDTH = 16,
    parameter int NCH   = 4,
    parameter int SELW  = 2
);
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic [SELW-1:0]      sel;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_ch;
    logic                 out_valid;
    logic                 out_ready;
    logic                 sel_err;

    modport master (
        output in_data, in_valid, sel, out_ready,
        input  in_ready, out_data, out_ch, out_valid, sel_err
    );

    modport slave (
        input  in_data, in_valid, sel, out_ready,
        output in_ready, out_data, out_ch, out_valid, sel_err
    );
endinterface

// File: rtl/stream_mux_rr.sv
// NCH-to-1 valid/ready stream mux with a registered output stage.
// Channel choice is either a fixed select or round-robin arbitration.
module stream_mux_rr #(
    parameter int WIDTH   = 16,
    parameter int NCH     = 4,
    parameter int SELW    = 2,
    parameter int RR_MODE = 1
) (
    input  logic           clk,
    input  logic           rst,
    stream_mux_rr_if.slave bus
);
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [SELW-1:0]  ch_q,    ch_d;
    logic [SELW-1:0]  ptr_q,   ptr_d;
    logic             err_q,   err_d;

    logic             accept;
    logic             grant_vld;
    logic [SELW-1:0]  grant_idx;
    logic [WIDTH-1:0] grant_data;
    logic             sel_ok;
    logic [NCH-1:0]   in_ready_w;

    assign accept = !valid_q || bus.out_ready;

    // Round-robin picks the lowest requester at or above ptr, else wraps to the lowest overall.
    always_comb begin : grant_logic
        logic            hi_found, lo_found, fixed_hit;
        logic [SELW-1:0] hi_idx, lo_idx;
        // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
        hi_found  = 1'b0;
        lo_found  = 1'b0;
        fixed_hit = 1'b0;
        hi_idx    = '0;
        lo_idx    = '0;
        sel_ok    = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (bus.in_valid[i]) begin
                lo_found = 1'b1;
                lo_idx   = SELW'(i);
                if (SELW'(i) >= ptr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = SELW'(i);
                end
            end
        end
        for (int i = 0; i < NCH; i++) begin
            if (bus.sel == SELW'(i)) begin
                sel_ok    = 1'b1;
                fixed_hit = bus.in_valid[i];
            end
        end
        if (RR_MODE != 0) begin
            grant_vld = hi_found || lo_found;
            grant_idx = hi_found ? hi_idx : lo_idx;
        end else begin
            grant_vld = fixed_hit;
            grant_idx = bus.sel;
        end
    end

    always_comb begin
        grant_data = '0;
        in_ready_w = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant_idx == SELW'(i)) begin
                grant_data    = bus.in_data[i*WIDTH +: WIDTH];
                in_ready_w[i] = !rst && accept && grant_vld;
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ch_d    = ch_q;
        ptr_d   = ptr_q;
        if (accept) begin
            valid_d = grant_vld;
            if (grant_vld) begin
                data_d = grant_data;
                ch_d   = grant_idx;
                if (RR_MODE != 0) begin
                    ptr_d = (grant_idx == SELW'(NCH - 1)) ? '0 : grant_idx + SELW'(1);
                end
            end
        end
        err_d = (RR_MODE == 0) && accept && !sel_ok;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ch_q    <= '0;
            ptr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_ch    = ch_q;
    assign bus.sel_err   = err_q;
endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: three instances (4ch RR, 4ch fixed, 3ch fixed) checked
// against a cycle model built from the arbitration rules, plus directed scenarios.
module tb_stream_mux_rr;
    localparam int NI = 3;

    logic clk;
    logic rst;

    logic [3:0]  v_s   [NI];
    logic [15:0] d_s   [NI][4];
    logic [1:0]  sel_s [NI];
    logic        rdy_s [NI];

    logic        m_valid [NI];
    logic [15:0] m_data  [NI];
    int          m_ch    [NI];
    int          m_ptr   [NI];
    logic        m_err   [NI];

    logic [3:0]  o_ready [NI];
    logic [15:0] o_data  [NI];
    logic [1:0]  o_ch    [NI];
    logic        o_valid [NI];
    logic        o_err   [NI];

    int n_tests = 0;
    int n_fail  = 0;

    stream_mux_rr_if #(.WIDTH(16), .NCH(4), .SELW(2)) if0 ();
    stream_mux_rr_if #(.WIDTH(16), .NCH(4), .SELW(2)) if1 ();
    stream_mux_rr_if #(.WIDTH(16), .NCH(3), .SELW(2)) if2 ();

    stream_mux_rr #(.WIDTH(16), .NCH(4), .SELW(2), .RR_MODE(1)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    stream_mux_rr #(.WIDTH(16), .NCH(4), .SELW(2), .RR_MODE(0)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    stream_mux_rr #(.WIDTH(16), .NCH(3), .SELW(2), .RR_MODE(0)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    assign if0.in_data   = {d_s[0][3], d_s[0][2], d_s[0][1], d_s[0][0]};
    assign if0.in_valid  = v_s[0];
    assign if0.sel       = sel_s[0];
    assign if0.out_ready = rdy_s[0];
    assign if1.in_data   = {d_s[1][3], d_s[1][2], d_s[1][1], d_s[1][0]};
    assign if1.in_valid  = v_s[1];
    assign if1.sel       = sel_s[1];
    assign if1.out_ready = rdy_s[1];
    assign if2.in_data   = {d_s[2][2], d_s[2][1], d_s[2][0]};
    assign if2.in_valid  = v_s[2][2:0];
    assign if2.sel       = sel_s[2];
    assign if2.out_ready = rdy_s[2];

    assign o_ready[0] = if0.in_ready;
    assign o_ready[1] = if1.in_ready;
    assign o_ready[2] = {1'b0, if2.in_ready};
    assign o_data[0]  = if0.out_data;
    assign o_data[1]  = if1.out_data;
    assign o_data[2]  = if2.out_data;
    assign o_ch[0]    = if0.out_ch;
    assign o_ch[1]    = if1.out_ch;
    assign o_ch[2]    = if2.out_ch;
    assign o_valid[0] = if0.out_valid;
    assign o_valid[1] = if1.out_valid;
    assign o_valid[2] = if2.out_valid;
    assign o_err[0]   = if0.sel_err;
    assign o_err[1]   = if1.sel_err;
    assign o_err[2]   = if2.sel_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int nch_of(int k);
        return (k == 2) ? 3 : 4;
    endfunction

    function automatic bit rr_of(int k);
        return (k == 0);
    endfunction

    // Channel that wins this cycle for instance k, or -1 when nobody is granted.
    function automatic int model_grant(int k);
        int n;
        n = nch_of(k);
        if (rr_of(k)) begin
            for (int o = 0; o < n; o++) begin
                int c;
                c = (m_ptr[k] + o) % n;
                if (v_s[k][c]) return c;
            end
            return -1;
        end
        if (int'(sel_s[k]) < n && v_s[k][sel_s[k]]) return int'(sel_s[k]);
        return -1;
    endfunction

    function automatic logic [3:0] exp_ready(int k);
        int g;
        g = model_grant(k);
        if (rst) return 4'b0000;
        if ((!m_valid[k] || rdy_s[k]) && g >= 0) return 4'(1 << g);
        return 4'b0000;
    endfunction

    task automatic model_update();
        for (int k = 0; k < NI; k++) begin
            if (rst) begin
                m_valid[k] = 1'b0;
                m_data[k]  = 16'h0;
                m_ch[k]    = 0;
                m_ptr[k]   = 0;
                m_err[k]   = 1'b0;
            end else begin
                bit acc;
                int g;
                acc = !m_valid[k] || rdy_s[k];
                g   = model_grant(k);
                m_err[k] = !rr_of(k) && acc && (int'(sel_s[k]) >= nch_of(k));
                if (acc) begin
                    if (g >= 0) begin
                        m_valid[k] = 1'b1;
                        m_data[k]  = d_s[k][g];
                        m_ch[k]    = g;
                        if (rr_of(k)) m_ptr[k] = (g + 1) % nch_of(k);
                    end else begin
                        m_valid[k] = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("%s.in_ready[%0d]", tag, k), 32'(o_ready[k]), 32'(exp_ready(k)));
            check($sformatf("%s.out_valid[%0d]", tag, k), 32'(o_valid[k]), 32'(m_valid[k]));
            check($sformatf("%s.sel_err[%0d]", tag, k), 32'(o_err[k]), 32'(m_err[k]));
            if (m_valid[k]) begin
                check($sformatf("%s.out_data[%0d]", tag, k), 32'(o_data[k]), 32'(m_data[k]));
                check($sformatf("%s.out_ch[%0d]", tag, k), 32'(o_ch[k]), 32'(m_ch[k]));
            end
        end
    endtask

    task automatic step(input string tag);
        #1;
        compare_all(tag);
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic drive_all(input logic [3:0] valid, input logic rdy);
        for (int k = 0; k < NI; k++) begin
            v_s[k]   = valid;
            rdy_s[k] = rdy;
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < NI; k++) begin
            sel_s[k] = 2'd0;
            for (int i = 0; i < 4; i++) d_s[k][i] = 16'(16'h1000 * (k + 1) + i);
        end
        drive_all(4'b1111, 1'b1);
        @(posedge clk);
        model_update();
        @(negedge clk);

        // Reset held for a second cycle with every channel valid.
        step("rst");
        #1;
        check("rst.out_valid", 32'(o_valid[0]), 32'd0);
        check("rst.out_data", 32'(o_data[0]), 32'd0);
        check("rst.out_ch", 32'(o_ch[0]), 32'd0);
        check("rst.in_ready", 32'(o_ready[0]), 32'd0);
        rst = 1'b0;
        #1;
        check("rst.first_grant", 32'(o_ready[0]), 32'b0001);
        step("rel");

        // Fixed select on the 4-channel fixed instance.
        sel_s[1]    = 2'd2;
        d_s[1][2]   = 16'hBEEF;
        #1;
        check("fix.in_ready", 32'(o_ready[1]), 32'b0100);
        step("fix1");
        check("fix.out_valid", 32'(o_valid[1]), 32'd1);
        check("fix.out_data", 32'(o_data[1]), 32'hBEEF);
        check("fix.out_ch", 32'(o_ch[1]), 32'd2);
        sel_s[1]  = 2'd3;
        d_s[1][3] = 16'h1234;
        step("fix2");
        check("fix.out_data2", 32'(o_data[1]), 32'h1234);
        check("fix.out_ch2", 32'(o_ch[1]), 32'd3);

        // Round-robin fairness from a freshly reset pointer.
        rst = 1'b1;
        step("rr_rst");
        rst = 1'b0;
        drive_all(4'b1111, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step("rr_all");
            check($sformatf("rr.all_ch%0d", i), 32'(o_ch[0]), 32'(i % 4));
        end
        v_s[0] = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            step("rr_odd");
            check($sformatf("rr.odd_ch%0d", i), 32'(o_ch[0]), (i % 2 == 1) ? 32'd3 : 32'd1);
        end

        // Back-pressure holds the beat, then drain and capture share one edge.
        v_s[0]    = 4'b0001;
        d_s[0][0] = 16'h00AA;
        d_s[0][1] = 16'h0BB1;
        step("bp_load");
        check("bp.loaded", 32'(o_data[0]), 32'h00AA);
        rdy_s[0] = 1'b0;
        v_s[0]   = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp.in_ready", 32'(o_ready[0]), 32'd0);
            step("bp_hold");
            check("bp.hold_data", 32'(o_data[0]), 32'h00AA);
            check("bp.hold_ch", 32'(o_ch[0]), 32'd0);
            check("bp.hold_valid", 32'(o_valid[0]), 32'd1);
        end
        rdy_s[0] = 1'b1;
        #1;
        check("bp.release_ready", 32'(o_ready[0]), 32'b0010);
        step("bp_release");
        check("bp.next_valid", 32'(o_valid[0]), 32'd1);
        check("bp.next_data", 32'(o_data[0]), 32'h0BB1);
        check("bp.next_ch", 32'(o_ch[0]), 32'd1);

        // Out-of-range select on the 3-channel fixed instance.
        v_s[2]   = 4'b0000;
        rdy_s[2] = 1'b1;
        sel_s[2] = 2'd0;
        step("err_empty");
        sel_s[2] = 2'd3;
        v_s[2]   = 4'b0111;
        #1;
        check("err.in_ready", 32'(o_ready[2]), 32'd0);
        check("err.empty", 32'(o_valid[2]), 32'd0);
        step("err_hit");
        check("err.pulse", 32'(o_err[2]), 32'd1);
        check("err.no_beat", 32'(o_valid[2]), 32'd0);
        sel_s[2] = 2'd0;
        v_s[2]   = 4'b0000;
        step("err_clear");
        check("err.one_cycle", 32'(o_err[2]), 32'd0);

        // Reset while a beat is held and ptr sits at 2.
        rst = 1'b1;
        step("mid_rst0");
        rst       = 1'b0;
        v_s[0]    = 4'b0010;
        d_s[0][1] = 16'h5555;
        rdy_s[0]  = 1'b1;
        step("mid_load");
        rdy_s[0] = 1'b0;
        step("mid_hold");
        check("mid.held", 32'(o_data[0]), 32'h5555);
        rst = 1'b1;
        step("mid_rst");
        check("mid.cleared", 32'(o_valid[0]), 32'd0);
        rst = 1'b0;
        drive_all(4'b1111, 1'b1);
        #1;
        check("mid.grant_ch0", 32'(o_ready[0]), 32'b0001);
        step("mid_after");
        check("mid.out_ch0", 32'(o_ch[0]), 32'd0);

        // Randomised traffic with occasional resets.
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 63) == 0);
            for (int k = 0; k < NI; k++) begin
                v_s[k]   = 4'($urandom);
                sel_s[k] = 2'($urandom);
                rdy_s[k] = ($urandom_range(0, 3) != 0);
                for (int i = 0; i < 4; i++) d_s[k][i] = 16'($urandom);
            end
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
